// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin shared UART transmitter with registered serial output
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                            pclk,
    input  logic                            areset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            frame_done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_PEN  = BW'(CLK_DIV - 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_baud;
    logic [CW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parity;
    logic [IW-1:0]         r_last;
    logic                  r_tx;
    logic                  r_busy;
    logic [IW-1:0]         r_grant_id;
    logic                  r_frame_done;

    logic                  w_found;
    logic [IW-1:0]         w_win;
    logic [IW-1:0]         w_idx;
    logic                  w_grant;
    logic                  w_baud_wrap;
    logic [DATA_WIDTH-1:0] w_data;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IW'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_grant     = (r_state == S_IDLE) && !areset && w_found;
    assign req_ready   = w_grant ? (NUM_REQ'(1) << w_win) : '0;
    assign w_data      = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_baud_wrap = (r_baud == BAUD_MAX);

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;
    assign frame_done = r_frame_done;

    always_ff @(posedge pclk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_last       <= LAST_RST;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_grant_id   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_shift    <= w_data;
                        r_parity   <= (^w_data) ^ PAR_ODD;
                        r_last     <= w_win;
                        r_grant_id <= w_win;
                        r_baud     <= '0;
                        r_bit      <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    // Raised one edge early so the registered pulse lands on the final stop cycle.
                    if (r_bit == STOP_LAST && r_baud == BAUD_PEN) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
